palette_arbiter: RTL
====================

Name: palette_arbiter

Overview:
- Shares a single 16-entry, 12-bit (4:4:4 RGB) writable palette between NREQ sprite/background layer requesters.
- Round-robin arbitration grants one lookup per clock. The granted 4-bit colour index is resolved to RGB one cycle later, tagged with the requester ID and a transparency flag.
- Sits between the per-sprite ROM readers and the VGA colour mapper.
- Palette contents are loaded at runtime through a write port by the game-state logic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 3, width of requester ID field; must satisfy 2^IDW >= NREQ.
- TRANSP_IDX, 0, palette index treated as transparent.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester lookup request, level.
- idx  in  4*NREQ  flat index bus; requester i uses bits [4i+3:4i].
- gnt  out  NREQ  one-hot grant, combinational, same cycle as req.
- freeze  in  1  when 1, no grants are issued.
- wr_en  in  1  palette write strobe.
- wr_addr  in  4  palette entry to write.
- wr_data  in  12  {R,G,B} 4 bits each.
- rsp_valid  out  1  response valid.
- rsp_id  out  IDW  requester ID of the response.
- red, green, blue  out  4 each  looked-up colour.
- transparent  out  1  1 when the looked-up index == TRANSP_IDX.

Behaviour:
- Reset (synchronous, active-high):
  - All 16 palette entries cleared to 12'h000.
  - RR pointer = 0.
  - rsp_valid = 0, rsp_id = 0, red/green/blue = 0, transparent = 0.
  - gnt = 0 while Reset is high.
- Arbitration:
  - Search starts at the RR pointer and proceeds upward modulo NREQ. The first i with req[i]=1 gets gnt[i]=1. At most one gnt bit is set.
  - No req, or freeze=1: gnt = 0 and the pointer holds.
  - After a grant to i, the pointer becomes (i+1) mod NREQ on the next edge. This bounds wait time to NREQ-1 cycles for a continuously requesting master.
- Handshake:
  - A requester holds req and idx stable until it sees gnt.
  - A transfer occurs on any edge where req[i] & gnt[i].
  - The requester may keep req high to issue back-to-back lookups; these are granted only when the RR order reaches it again, unless no other req is pending.
- Response (registered, latency 1):
  - On the edge after a transfer: rsp_valid=1, rsp_id=i, {red,green,blue}=palette[idx_i], transparent=(idx_i==TRANSP_IDX).
  - With no transfer, rsp_valid=0 on the next edge. RGB, rsp_id and transparent hold their last values; consumers must qualify them with rsp_valid.
- Palette write:
  - wr_en=1 writes wr_data to palette[wr_addr] on the edge.
  - Simultaneous write and lookup of the same entry in one cycle: the response returns the OLD entry (read-before-write). The new value is visible to lookups granted in the next cycle onward.
  - Writes are accepted regardless of freeze.
  - The transparency flag depends only on the index, never on palette content.
- freeze:
  - Intended for bulk palette reloads.
  - Asserting it mid-stream does not cancel a response already in flight from the previous cycle's grant.
- Reset mid-operation:
  - An in-flight response is discarded (rsp_valid=0 next cycle) and the palette is cleared.
  - Requesters must re-request.
- Out-of-range requester bits: none exist; only NREQ bits are arbitrated.

Test Plan:
- Reset, then write entry 5 = 12'hF87 and entry 0 = 12'h123. Request from req[2] with idx=5 → gnt=4'b0100 same cycle; next cycle rsp_valid=1, rsp_id=2, RGB=F,8,7, transparent=0.
- All four req high continuously, pointer=0 → grants 0,1,2,3,0,1 on consecutive cycles; rsp_id sequence is the same, delayed by 1.
- Lookup idx=0 from req[1] → rsp RGB=1,2,3 with transparent=1. Lookup idx=3 (unwritten) → RGB=0,0,0, transparent=0.
- Same cycle: wr_en to entry 5 with 12'hABC while req[0] reads idx=5 (old F87) → response F,8,7. Read again next cycle → A,B,C.
- freeze=1 with req=4'b1111 for 3 cycles → gnt=0 and rsp_valid=0 after the in-flight response; pointer unchanged. Deassert freeze → grant resumes at the held pointer.
- Assert Reset in the cycle after a grant → rsp_valid=0, palette reads 000, next grant goes to the lowest pending req.

Source files
------------

// File: rtl/palette_arbiter.sv
// palette_arbiter
//   Shares one 16-entry, 12-bit (4:4:4 RGB) writable palette between NREQ
//   sprite/background layer requesters. A round-robin arbiter grants one
//   lookup per clock; the granted colour index is resolved to RGB on the
//   following edge and returned with the requester ID and a transparency flag.
//
// Ports
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   req          per-requester lookup request (level, held until granted)
//   idx          flat index bus, requester i uses idx[4i+3:4i]
//   gnt          one-hot grant, combinational in the request cycle
//   freeze       suppresses all grants while high (palette writes continue)
//   wr_en        palette write strobe
//   wr_addr      palette entry to write
//   wr_data      {R,G,B}, 4 bits each
//   rsp_valid    response valid (one cycle after a grant)
//   rsp_id       requester ID of the response
//   red/green/blue  looked-up colour; hold their value when rsp_valid=0
//   transparent  looked-up index equals TRANSP_IDX
module palette_arbiter #(
  parameter int         NREQ       = 4,
  parameter int         IDW        = 3,
  parameter logic [3:0] TRANSP_IDX = 4'd0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] idx,
  output logic [NREQ-1:0]   gnt,
  input  logic              freeze,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [11:0]       wr_data,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              transparent
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [11:0]    pal_q [16];
  logic [11:0]    pal_d [16];
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [11:0]    rgb_q, rgb_d;
  logic           transp_q, transp_d;

  logic           hi_found_s, lo_found_s;
  logic [IDW-1:0] hi_id_s, lo_id_s, win_id_s;
  logic           grant_en_s;
  logic [3:0]     sel_idx_s;
  logic [NREQ-1:0] gnt_s;

  // Round-robin search: the first requester at or above the pointer wins
  // ("hi" pass); if none exists the search wraps to the lowest requester
  // overall ("lo" pass). Ternaries keep the first hit of each pass.
  always_comb begin
    hi_found_s = 1'b0;
    hi_id_s    = '0;
    lo_found_s = 1'b0;
    lo_id_s    = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_id_s    = (req[i] && !hi_found_s && (i >= int'(ptr_q))) ? IDW'(i) : hi_id_s;
      hi_found_s = hi_found_s | (req[i] && (i >= int'(ptr_q)));
      lo_id_s    = (req[i] && !lo_found_s) ? IDW'(i) : lo_id_s;
      lo_found_s = lo_found_s | req[i];
    end
    win_id_s   = hi_found_s ? hi_id_s : lo_id_s;
    grant_en_s = lo_found_s && !freeze && !Reset;
  end

  // One-hot grant decode and mux of the winner's colour index.
  always_comb begin
    gnt_s     = '0;
    sel_idx_s = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_s[i]  = grant_en_s && (win_id_s == IDW'(i));
      sel_idx_s = (win_id_s == IDW'(i)) ? idx[4*i +: 4] : sel_idx_s;
    end
  end

  // Next-state: response capture, pointer advance and palette write.
  // The lookup reads pal_q, so a same-cycle write to the same entry is
  // seen only by lookups granted from the next cycle on.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = grant_en_s;
    rsp_id_d    = rsp_id_q;
    rgb_d       = rgb_q;
    transp_d    = transp_q;
    pal_d       = pal_q;
    if (grant_en_s) begin
      rsp_id_d = win_id_s;
      rgb_d    = pal_q[sel_idx_s];
      transp_d = (sel_idx_s == TRANSP_IDX);
      if (int'(win_id_s) == NREQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_id_s + IDW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
    if (wr_en) begin
      pal_d[wr_addr] = wr_data;
    end else begin
      pal_d[wr_addr] = pal_q[wr_addr];
    end
  end

  // State registers with synchronous reset; reset also drops any response in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rgb_q       <= 12'h000;
      transp_q    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= 12'h000;
      end
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rgb_q       <= rgb_d;
      transp_q    <= transp_d;
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= pal_d[i];
      end
    end
  end

  assign gnt         = gnt_s;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign transparent = transp_q;

endmodule
